// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_pkg : shared state type and default widths for seq_det     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seq_det_pkg;

  localparam int PAT_W_DEFAULT = 8;
  localparam int LEN_W_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 8;
  localparam int TO_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_core : serial history, fill count and masked pattern hit   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] w_fill_nxt;
  logic [PAT_W-1:0] w_mask;

  // Hit is judged on the history as it will look after this bit lands,
  // so the registered match pulse appears one cycle after the bit.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], din};
    w_fill_nxt = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    w_mask     = ~({PAT_W{1'b1}} << len);
    hit        = shift && (w_fill_nxt >= len) &&
                 (((w_hist_nxt ^ pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_ctrl : configurable serial pattern detection run control   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int TO_W  = TO_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             data_in,
  input  logic             data_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat, w_pat_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [CNT_W-1:0] r_tgt, w_tgt_nxt;
  logic [TO_W-1:0]  r_to, w_to_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt, w_count_inc;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt, w_to_inc;
  logic             r_match, w_match_nxt;
  logic             r_done, w_done_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic             w_cfg_legal;
  logic             w_clear;
  logic             w_shift;
  logic             w_hit;

  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W)) &&
                       (cfg_target != '0);
  assign w_shift     = (r_state == ST_RUN) && data_valid;
  assign w_count_inc = r_count + 1'b1;
  assign w_to_inc    = r_to_cnt + 1'b1;

  seq_det_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .shift   (w_shift),
    .din     (data_in),
    .pattern (r_pat),
    .len     (r_len),
    .hit     (w_hit)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_tgt_nxt     = r_tgt;
    w_to_nxt      = r_to;
    w_count_nxt   = r_count;
    w_to_cnt_nxt  = r_to_cnt;
    w_match_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_cfg_err_nxt = 1'b0;
    w_clear       = 1'b0;
    case (r_state)
      ST_IDLE, ST_ARMED: begin
        // A config offer takes priority over start/abort in the same cycle.
        if (cfg_valid) begin
          if (w_cfg_legal) begin
            w_pat_nxt   = cfg_pattern;
            w_len_nxt   = cfg_len;
            w_tgt_nxt   = cfg_target;
            w_to_nxt    = cfg_timeout;
            w_state_nxt = ST_ARMED;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end else if (r_state == ST_ARMED && abort) begin
          w_pat_nxt   = '0;
          w_len_nxt   = '0;
          w_tgt_nxt   = '0;
          w_to_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_state == ST_ARMED && start) begin
          w_clear      = 1'b1;
          w_count_nxt  = '0;
          w_to_cnt_nxt = '0;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_ARMED;
        end else if (w_hit) begin
          w_match_nxt  = 1'b1;
          w_count_nxt  = w_count_inc;
          w_to_cnt_nxt = '0;
          if (w_count_inc == r_tgt) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_ARMED;
          end
        end else begin
          w_to_cnt_nxt = w_to_inc;
          if (r_to != '0 && w_to_inc == r_to) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_ARMED;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_tgt     <= '0;
      r_to      <= '0;
      r_count   <= '0;
      r_to_cnt  <= '0;
      r_match   <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_tgt     <= w_tgt_nxt;
      r_to      <= w_to_nxt;
      r_count   <= w_count_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_match   <= w_match_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign cfg_ready   = (r_state != ST_RUN);
  assign busy        = (r_state == ST_RUN);
  assign match       = r_match;
  assign match_count = r_count;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire
